rv_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit implementing the RV32M/RV64M integer ops. It plugs into the execute stage beside the ALU.
- Accepts one operation at a time. Stalls the pipeline while iterating, then returns a single result with a one-cycle done pulse.
- Width and per-cycle throughput are parametrised so the same block serves XLEN=32 and XLEN=64 cores.

---
 rtl/rv_muldiv_unit_if.sv | 32 +++
 rtl/rv_muldiv_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the mul/div unit.
// Latency: none, this is wiring only.
// Backpressure: the unit holds the pipeline through stall; there is no ready signal.
//
// Ports (grouped here):
//   start/op/rs1/rs2/flush : pipeline -> unit request and abort
//   busy/stall/done/result : unit -> pipeline status and result
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    // Pipeline side
    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, stall, done, result
    );

    // Unit side
    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit sitting beside the ALU.
// Latency: XLEN/UNROLL BUSY cycles then a one-cycle DONE; div-by-zero and signed overflow go straight to DONE.
// Backpressure: stall holds the pipeline from acceptance through BUSY; start is ignored unless IDLE, flush aborts.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   mdu      : rv_muldiv_unit_if slave (start/op/rs1/rs2/flush in, busy/stall/done/result out)
// Parameters: XLEN in {32,64}; UNROLL in {1,2,4} and must divide XLEN.
module rv_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    rv_muldiv_unit_if.slave mdu
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q;      // mul: upper product half; div: partial remainder
    logic [XLEN-1:0] lo_q;      // mul: multiplier / lower product; div: dividend -> quotient
    logic [XLEN-1:0] d_q;       // mul: multiplicand magnitude; div: divisor magnitude
    logic            neg_q;     // negate product or quotient at the end
    logic            rneg_q;    // negate remainder at the end (dividend sign)
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;

    // Status
    logic busy_c, stall_c, done_c;
    logic accept;
    logic last_iter;

    // Operand decode at the request port
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    // Iteration datapath
    logic [XLEN-1:0] h_it, l_it;
    logic [XLEN:0]   sum_it, t_it;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    // Sign fix-up and result select
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, final_res;

    assign accept    = (state == S_IDLE) && mdu.start && !mdu.flush;
    assign last_iter = (cnt_q == CW'(XLEN - UNROLL));

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
    // Signed operands are reduced to magnitudes and the sign reapplied at the end, which
    // equals a signed product/division on XLEN+1-bit extended operands.
    assign a_signed = (mdu.op == 3'd1) || (mdu.op == 3'd2) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
    assign b_signed = (mdu.op == 3'd1) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
    assign a_neg    = a_signed && mdu.rs1[XLEN-1];
    assign b_neg    = b_signed && mdu.rs2[XLEN-1];
    // -(-2^(XLEN-1)) keeps the same bit pattern, which is the correct unsigned magnitude.
    assign a_mag    = a_neg ? -mdu.rs1 : mdu.rs1;
    assign b_mag    = b_neg ? -mdu.rs2 : mdu.rs2;

    assign div_zero = mdu.op[2] && (mdu.rs2 == '0);
    assign div_ovf  = mdu.op[2] && !mdu.op[0]
                      && (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (mdu.rs2 == '1);
    assign special  = div_zero || div_ovf;

    // op[1] set selects REM/REMU, clear selects DIV/DIVU
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = mdu.op[1] ? mdu.rs1 : '1;
        end else begin
            special_res = mdu.op[1] ? '0 : mdu.rs1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                stall_c = mdu.start && !mdu.flush;
                if (accept) begin
                    state_nxt = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                busy_c  = 1'b1;
                stall_c = 1'b1;
                if (mdu.flush) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // flush here is ignored: the result is already on its way
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // UNROLL radix-2 steps per cycle.
    // Multiply: LSB-first shift-add, {hi,lo} shifts right with the carry entering hi.
    // Divide: restoring, {rem,dividend} shifts left and the quotient bit fills lo[0].
    always_comb begin
        h_it   = hi_q;
        l_it   = lo_q;
        sum_it = '0;
        t_it   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (!op_q[2]) begin
                sum_it = {1'b0, h_it} + (l_it[0] ? {1'b0, d_q} : '0);
                l_it   = {sum_it[0], l_it[XLEN-1:1]};
                h_it   = sum_it[XLEN:1];
            end else begin
                t_it = {h_it, l_it[XLEN-1]};
                l_it = {l_it[XLEN-2:0], 1'b0};
                if (t_it >= {1'b0, d_q}) begin
                    // difference is below the divisor, so XLEN bits hold it exactly
                    h_it    = t_it[XLEN-1:0] - d_q;
                    l_it[0] = 1'b1;
                end else begin
                    h_it = t_it[XLEN-1:0];
                end
            end
        end
        hi_nxt = h_it;
        lo_nxt = l_it;
    end

    // Final result is built from the last iteration's outputs so it can be
    // registered on the same edge that enters DONE.
    assign prod     = {hi_nxt, lo_nxt};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -lo_nxt : lo_nxt;
    assign r_fix    = rneg_q ? -hi_nxt : hi_nxt;

    always_comb begin
        final_res = '0;
        if (op_q[2]) begin
            final_res = op_q[1] ? r_fix : q_fix;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            d_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= mdu.op;
            hi_q   <= '0;
            cnt_q  <= '0;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (mdu.op[2]) begin
                lo_q <= a_mag;
                d_q  <= b_mag;
            end else begin
                lo_q <= b_mag;
                d_q  <= a_mag;
            end
            if (special) begin
                result_q <= special_res;
            end
        end else if ((state == S_BUSY) && !mdu.flush) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CW'(UNROLL);
            if (last_iter) begin
                result_q <= final_res;
            end
        end
    end

    assign mdu.busy   = busy_c;
    assign mdu.stall  = stall_c;
    assign mdu.done   = done_c;
    assign mdu.result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit at XLEN=32/UNROLL=1 and XLEN=64/UNROLL=4.
// Latency: n/a. Backpressure: n/a.
// Expected results are queued when an op is issued and popped when done is seen.
module tb_rv_muldiv_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv_muldiv_unit_if #(.XLEN(32)) i32 ();
    rv_muldiv_unit_if #(.XLEN(64)) i64 ();

    rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut32 (
        .clk (clk),
        .rst (rst),
        .mdu (i32)
    );

    rv_muldiv_unit #(.XLEN(64), .UNROLL(4)) dut64 (
        .clk (clk),
        .rst (rst),
        .mdu (i64)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sb32[$];
    logic [63:0] sb64[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit unit; called right after a negedge (+1).
    task automatic op32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int nbusy, input string tag);
        int cyc;
        int stalls;
        logic [31:0] want;
        i32.start = 1'b1;
        i32.op    = f;
        i32.rs1   = a;
        i32.rs2   = b;
        sb32.push_back(exp);
        #1;
        stalls = i32.stall ? 1 : 0;
        @(negedge clk);
        // operand changes after acceptance must not matter
        i32.start = 1'b0;
        i32.op    = 3'($urandom);
        i32.rs1   = $urandom;
        i32.rs2   = $urandom;
        #1;
        cyc = 1;
        while (!i32.done && cyc < 200) begin
            if (i32.stall) stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(nbusy + 1));
        check({tag, " stall cycles"}, 64'(stalls), 64'(nbusy + 1));
        check({tag, " stall in done"}, 64'(i32.stall), 64'd0);
        want = '0;
        if (sb32.size() > 0) want = sb32.pop_front();
        check({tag, " result"}, 64'(i32.result), 64'(want));
        @(negedge clk);
        #1;
        check({tag, " done width"}, 64'(i32.done), 64'd0);
        check({tag, " result hold"}, 64'(i32.result), 64'(want));
    endtask

    // Issue one op on the 64-bit unit, optionally pulsing start while it is busy.
    task automatic op64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int nbusy, input bit poke, input string tag);
        int cyc;
        logic [63:0] want;
        i64.start = 1'b1;
        i64.op    = f;
        i64.rs1   = a;
        i64.rs2   = b;
        sb64.push_back(exp);
        @(negedge clk);
        i64.start = 1'b0;
        #1;
        cyc = 1;
        while (!i64.done && cyc < 200) begin
            if (poke && (cyc == 3 || cyc == 7)) begin
                i64.start = 1'b1;
                i64.op    = 3'($urandom);
                i64.rs1   = {$urandom, $urandom};
                i64.rs2   = {$urandom, $urandom};
            end else begin
                i64.start = 1'b0;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        i64.start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(nbusy + 1));
        want = '0;
        if (sb64.size() > 0) want = sb64.pop_front();
        check({tag, " result"}, i64.result, want);
        @(negedge clk);
        #1;
        check({tag, " done width"}, 64'(i64.done), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " idle after"}, 64'(i64.busy), 64'd0);
        check({tag, " result hold"}, i64.result, want);
    endtask

    // Start a DIVU, then abort in BUSY cycle 10 with flush (use_rst=0) or rst (use_rst=1).
    task automatic abort32(input bit use_rst, input string tag);
        bit dseen;
        dseen     = 1'b0;
        i32.start = 1'b1;
        i32.op    = 3'd5;
        i32.rs1   = 32'd1000;
        i32.rs2   = 32'd3;
        @(negedge clk);
        i32.start = 1'b0;
        #1;
        repeat (9) begin
            if (i32.done) dseen = 1'b1;
            @(negedge clk);
            #1;
        end
        check({tag, " busy before abort"}, 64'(i32.busy), 64'd1);
        if (use_rst) rst = 1'b1;
        else         i32.flush = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        i32.flush = 1'b0;
        #1;
        if (i32.done) dseen = 1'b1;
        check({tag, " busy after abort"}, 64'(i32.busy), 64'd0);
        check({tag, " no done"}, 64'(dseen), 64'd0);
        check({tag, " stall after abort"}, 64'(i32.stall), 64'd0);
        if (use_rst) check({tag, " result cleared"}, 64'(i32.result), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        i32.start = 1'b0; i32.op = '0; i32.rs1 = '0; i32.rs2 = '0; i32.flush = 1'b0;
        i64.start = 1'b0; i64.op = '0; i64.rs1 = '0; i64.rs2 = '0; i64.flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy32",   64'(i32.busy),   64'd0);
        check("reset done32",   64'(i32.done),   64'd0);
        check("reset stall32",  64'(i32.stall),  64'd0);
        check("reset result32", 64'(i32.result), 64'd0);
        check("reset busy64",   64'(i64.busy),   64'd0);
        check("reset result64", i64.result,      64'd0);

        // Multiply
        op32(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, "MUL 7*-3");
        op32(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "MULH min*min");
        op32(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "MULHU");
        op32(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "MULHSU");

        // Divide
        op32(3'd5, 32'd100,       32'd7, 32'd14,        32, "DIVU 100/7");
        op32(3'd7, 32'd100,       32'd7, 32'd2,         32, "REMU 100/7");
        op32(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, "DIV -7/2");
        op32(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, "REM -7/2");

        // Special cases, no BUSY cycles
        op32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIV ovf");
        op32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "REM ovf");
        op32(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, "DIVU /0");
        op32(3'd7, 32'd5,         32'd0,         32'd5,         0, "REMU /0");
        op32(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0, "REM /0");

        // Abort by flush and by reset, each followed straight away by a new op
        abort32(1'b0, "flush");
        op32(3'd5, 32'd100, 32'd7, 32'd14, 32, "DIVU after flush");
        abort32(1'b1, "reset");
        op32(3'd7, 32'd100, 32'd7, 32'd2, 32, "REMU after reset");

        // start together with flush: nothing accepted
        i32.start = 1'b1;
        i32.flush = 1'b1;
        i32.op    = 3'd0;
        i32.rs1   = 32'd3;
        i32.rs2   = 32'd4;
        #1;
        check("start+flush stall", 64'(i32.stall), 64'd0);
        @(negedge clk);
        i32.start = 1'b0;
        i32.flush = 1'b0;
        #1;
        check("start+flush busy", 64'(i32.busy), 64'd0);
        check("start+flush done", 64'(i32.done), 64'd0);

        // 64-bit, UNROLL=4
        op64(3'd0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003,
             64'h0000_0003_0000_0000, 16, 1'b1, "MUL64 with start pokes");
        op64(3'd5, 64'd1000, 64'd3, 64'd333, 16, 1'b0, "DIVU64");
        op64(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 16, 1'b0, "DIV64");

        check("scoreboard32 empty", 64'(sb32.size()), 64'd0);
        check("scoreboard64 empty", 64'(sb64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
